// File: rtl/pwm_peripheral_if.sv
// PWM peripheral bus: config bytes from the SPI register file
// in, registered pin drive and period strobe out.
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] pwm_out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  pwm_out,
    input  period_start
  );

  modport slave (
    input  en_reg_out_7_0,
    input  en_reg_out_15_8,
    input  en_reg_pwm_7_0,
    input  en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output pwm_out,
    output period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-pin PWM: shared prescaler, 8-bit counter and duty.
// Ports: clk, rst_n (sync, active-low), bus (slave modport).
// PWM_DUTY_SHADOW_EN: latch duty only at period wrap.
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 12
) (
  input  logic clk,
  input  logic rst_n,
  pwm_peripheral_if.slave bus
);

  localparam logic [15:0] PS = 16'(PRESCALE);

  logic [15:0] presc_q, presc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] out_q, out_d;
  logic        ps_q, ps_d;
  logic        tick, wrap, level;
  logic [7:0]  duty_eff;
  logic [15:0] en_out, en_pwm;

  assign en_out = {bus.en_reg_out_15_8,
                   bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8,
                   bus.en_reg_pwm_7_0};

  assign tick = (presc_q == PS);
  assign wrap = tick && (cnt_q == 8'hFF);

`ifdef PWM_DUTY_SHADOW_EN
  logic [7:0] duty_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q <= 8'h00;
    end else if (wrap) begin
      duty_q <= bus.pwm_duty_cycle;
    end
  end
  assign duty_eff = duty_q;
`else
  assign duty_eff = bus.pwm_duty_cycle;
`endif

  // 0xFF is special-cased so full duty has no low count at 255.
  assign level = (duty_eff == 8'hFF) ||
                 (cnt_q < duty_eff);

  always_comb begin
    presc_d = tick ? 16'h0000 : presc_q + 16'h0001;
    cnt_d   = tick ? cnt_q + 8'h01 : cnt_q;
    ps_d    = wrap;
    out_d   = en_out & (~en_pwm | {16{level}});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= 16'h0000;
      cnt_q   <= 8'h00;
      out_q   <= 16'h0000;
      ps_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ps_q    <= ps_d;
    end
  end

  assign bus.pwm_out      = out_q;
  assign bus.period_start = ps_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed self-checking bench for pwm_peripheral.
// Two instances: PRESCALE=0 and PRESCALE=2.
module tb_pwm_peripheral;

  logic clk;
  logic rst0_n, rst2_n;
  int   n_chk, n_fail;

  pwm_peripheral_if bus0 ();
  pwm_peripheral_if bus2 ();

  pwm_peripheral #(.PRESCALE(0)) dut0 (
    .clk  (clk),
    .rst_n(rst0_n),
    .bus  (bus0.slave)
  );

  pwm_peripheral #(.PRESCALE(2)) dut2 (
    .clk  (clk),
    .rst_n(rst2_n),
    .bus  (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ps(input int w);
    return (w == 0) ? bus0.period_start
                    : bus2.period_start;
  endfunction

  function automatic logic [15:0] po(input int w);
    return (w == 0) ? bus0.pwm_out : bus2.pwm_out;
  endfunction

  // Steps until period_start is seen; n = steps or -1.
  task automatic wait_ps(input int w, input int budget,
                         output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (ps(w)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic cfg0(input logic [15:0] eo,
                      input logic [15:0] ep,
                      input logic [7:0] d);
    bus0.en_reg_out_7_0  = eo[7:0];
    bus0.en_reg_out_15_8 = eo[15:8];
    bus0.en_reg_pwm_7_0  = ep[7:0];
    bus0.en_reg_pwm_15_8 = ep[15:8];
    bus0.pwm_duty_cycle  = d;
  endtask

  int n, hi, bad, bad2, bad3;
  logic [15:0] v;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst0_n = 1'b0;
    rst2_n = 1'b0;
    cfg0(16'hFFFF, 16'hFFFF, 8'hFF);
    bus2.en_reg_out_7_0  = 8'h00;
    bus2.en_reg_out_15_8 = 8'h00;
    bus2.en_reg_pwm_7_0  = 8'h00;
    bus2.en_reg_pwm_15_8 = 8'h00;
    bus2.pwm_duty_cycle  = 8'h00;

    // 1: reset and release
    step();
    step();
    chk("rst_out", bus0.pwm_out, 32'h0);
    chk("rst_ps", bus0.period_start, 32'h0);
    rst0_n = 1'b1;
    step();
    step();
`ifdef PWM_DUTY_SHADOW_EN
    chk("rel_out", bus0.pwm_out, 32'h0000);
`else
    chk("rel_out", bus0.pwm_out, 32'hFFFF);
`endif
    wait_ps(0, 400, n);
    chk("first_ps", n + 2, 32'd256);

    // 2: single pin, half duty
    cfg0(16'h0001, 16'h0001, 8'h80);
    wait_ps(0, 300, n);
    wait_ps(0, 300, n);
    chk("t2_ps_lo", bus0.pwm_out[0], 32'h0);
    step();
    chk("t2_rise", bus0.pwm_out[0], 32'h1);
    hi  = 1;
    bad = 0;
    for (int i = 1; i < 256; i++) begin
      step();
      hi  += int'(bus0.pwm_out[0]);
      bad += int'(bus0.pwm_out[15:1] != 15'h0);
    end
    chk("t2_hi", hi, 32'd128);
    chk("t2_others", bad, 32'd0);

    // 3: duty extremes on all pins
    cfg0(16'hFFFF, 16'hFFFF, 8'h00);
    wait_ps(0, 300, n);
    wait_ps(0, 300, n);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      step();
      bad += int'(bus0.pwm_out != 16'h0000);
    end
    chk("t3_zero", bad, 32'd0);
    bus0.pwm_duty_cycle = 8'hFF;
    wait_ps(0, 300, n);
    wait_ps(0, 300, n);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      step();
      bad += int'(bus0.pwm_out != 16'hFFFF);
    end
    chk("t3_full", bad, 32'd0);

    // 4: mixed modes
    cfg0(16'hFF00, 16'h0F00, 8'h40);
    wait_ps(0, 300, n);
    wait_ps(0, 300, n);
    hi   = 0;
    bad  = 0;
    bad2 = 0;
    bad3 = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      v     = bus0.pwm_out;
      hi   += int'(v[8]);
      bad  += int'(v[15:12] != 4'hF);
      bad2 += int'(v[7:0] != 8'h00);
      bad3 += int'(v[11:8] != 4'h0 &&
                   v[11:8] != 4'hF);
    end
    chk("t4_hi", hi, 32'd64);
    chk("t4_static", bad, 32'd0);
    chk("t4_off", bad2, 32'd0);
    chk("t4_phase", bad3, 32'd0);

    // 5: duty write mid-period at pwm_cnt=0x20
    cfg0(16'h0001, 16'h0001, 8'h40);
    wait_ps(0, 300, n);
    wait_ps(0, 300, n);
    hi = 0;
    for (int c = 1; c <= 256; c++) begin
      step();
      hi += int'(bus0.pwm_out[0]);
      if (c == 32'h20) bus0.pwm_duty_cycle = 8'hC0;
    end
`ifdef PWM_DUTY_SHADOW_EN
    chk("t5_cur", hi, 32'd64);
`else
    chk("t5_cur", hi, 32'd192);
`endif
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      hi += int'(bus0.pwm_out[0]);
    end
    chk("t5_next", hi, 32'd192);

    // 6: PRESCALE=2, minimal duty, reset mid-period
    bus2.en_reg_out_7_0 = 8'h03;
    bus2.en_reg_pwm_7_0 = 8'h01;
    bus2.pwm_duty_cycle = 8'h01;
    rst2_n = 1'b1;
    wait_ps(2, 1000, n);
    wait_ps(2, 1000, n);
    hi = 0;
    for (int i = 0; i < 768; i++) begin
      step();
      hi += int'(bus2.pwm_out[0]);
    end
    chk("t6_hi", hi, 32'd3);
    chk("t6_static", bus2.pwm_out[1], 32'h1);
    // 0x90 counts after the last wrap, then reset
    for (int i = 0; i < 32'h90 * 3; i++) step();
    rst2_n = 1'b0;
    step();
    chk("t6_rst_out", bus2.pwm_out, 32'h0);
    chk("t6_rst_ps", bus2.period_start, 32'h0);
    step();
    rst2_n = 1'b1;
    wait_ps(2, 1000, n);
    chk("t6_restart", n, 32'd768);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
